// File: rtl/wb_stage_reg_if.sv
// Writeback-stage bus: MEM-stage results and controls in, register-file
// write port, hazard feedback and retire count out.
interface wb_stage_reg_if #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CNT_W       = 32
);
  logic                   stall;
  logic                   flush;
  logic                   valid_in;
  logic [WORD_LENGTH-1:0] ALUOut;
  logic [WORD_LENGTH-1:0] DataMemoryOut;
  logic                   MEM_R_EN;
  logic                   MEM_WB_EN;
  logic [REG_ADDR_W-1:0]  dest_in;
  logic [1:0]             load_size;
  logic                   load_signed;

  logic [WORD_LENGTH-1:0] RegisterFileWriteData;
  logic                   WB_EN;
  logic [REG_ADDR_W-1:0]  WB_Dest;
  logic                   MEM_R_ENOut;
  logic [CNT_W-1:0]       retire_count;

  modport master (
    output stall, flush, valid_in, ALUOut, DataMemoryOut, MEM_R_EN, MEM_WB_EN,
           dest_in, load_size, load_signed,
    input  RegisterFileWriteData, WB_EN, WB_Dest, MEM_R_ENOut, retire_count
  );

  modport slave (
    input  stall, flush, valid_in, ALUOut, DataMemoryOut, MEM_R_EN, MEM_WB_EN,
           dest_in, load_size, load_signed,
    output RegisterFileWriteData, WB_EN, WB_Dest, MEM_R_ENOut, retire_count
  );
endinterface

// File: rtl/wb_stage_reg.sv
// Writeback stage with MEM/WB register, load extraction and retire counter.
// Sub-word loads are honoured only when WB_SUBWORD_LOAD_EN is defined.
module wb_stage_reg #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CNT_W       = 32
) (
  input logic           clk,
  input logic           rst,
  wb_stage_reg_if.slave bus
);

  logic                   valid_q,     valid_d;
  logic                   mem_r_en_q,  mem_r_en_d;
  logic                   mem_wb_en_q, mem_wb_en_d;
  logic [REG_ADDR_W-1:0]  dest_q,      dest_d;
  logic [WORD_LENGTH-1:0] alu_out_q,   alu_out_d;
  logic [WORD_LENGTH-1:0] data_q,      data_d;
  logic [CNT_W-1:0]       retire_q,    retire_d;
  logic [WORD_LENGTH-1:0] load_data;

`ifdef WB_SUBWORD_LOAD_EN
  logic [1:0] size_q,   size_d;
  logic       signed_q, signed_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
`endif

  // Next-state: flush kills the slot, stall holds it, otherwise capture.
  always_comb begin
    valid_d     = valid_q;
    mem_r_en_d  = mem_r_en_q;
    mem_wb_en_d = mem_wb_en_q;
    dest_d      = dest_q;
    alu_out_d   = alu_out_q;
    data_d      = data_q;
`ifdef WB_SUBWORD_LOAD_EN
    size_d      = size_q;
    signed_d    = signed_q;
`endif
    if (bus.flush) begin
      valid_d     = 1'b0;
      mem_r_en_d  = 1'b0;
      mem_wb_en_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d     = bus.valid_in;
      mem_r_en_d  = bus.MEM_R_EN;
      mem_wb_en_d = bus.MEM_WB_EN;
      dest_d      = bus.dest_in;
      alu_out_d   = bus.ALUOut;
      data_d      = bus.DataMemoryOut;
`ifdef WB_SUBWORD_LOAD_EN
      size_d      = bus.load_size;
      signed_d    = bus.load_signed;
`endif
    end
    // The held instruction retires whenever it is allowed to leave.
    retire_d = retire_q;
    if (valid_q && !bus.stall) begin
      retire_d = retire_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      mem_r_en_q  <= 1'b0;
      mem_wb_en_q <= 1'b0;
      dest_q      <= '0;
      alu_out_q   <= '0;
      data_q      <= '0;
      retire_q    <= '0;
`ifdef WB_SUBWORD_LOAD_EN
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
`endif
    end else begin
      valid_q     <= valid_d;
      mem_r_en_q  <= mem_r_en_d;
      mem_wb_en_q <= mem_wb_en_d;
      dest_q      <= dest_d;
      alu_out_q   <= alu_out_d;
      data_q      <= data_d;
      retire_q    <= retire_d;
`ifdef WB_SUBWORD_LOAD_EN
      size_q      <= size_d;
      signed_q    <= signed_d;
`endif
    end
  end

`ifdef WB_SUBWORD_LOAD_EN
  // Little-endian lane pick from the low word; half ignores address bit 0.
  always_comb begin
    byte_sel = data_q[7:0];
    case (alu_out_q[1:0])
      2'd0:    byte_sel = data_q[7:0];
      2'd1:    byte_sel = data_q[15:8];
      2'd2:    byte_sel = data_q[23:16];
      default: byte_sel = data_q[31:24];
    endcase
    half_sel = alu_out_q[1] ? data_q[31:16] : data_q[15:0];
    case (size_q)
      2'b10:   load_data = {{(WORD_LENGTH-8){signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{(WORD_LENGTH-16){signed_q & half_sel[15]}}, half_sel};
      default: load_data = data_q;
    endcase
  end
`else
  logic unused_load_cfg;
  assign unused_load_cfg = ^{bus.load_size, bus.load_signed};
  assign load_data       = data_q;
`endif

  assign bus.WB_EN                 = valid_q & mem_wb_en_q & (dest_q != '0);
  assign bus.WB_Dest               = dest_q;
  assign bus.MEM_R_ENOut           = valid_q & mem_r_en_q;
  assign bus.RegisterFileWriteData = mem_r_en_q ? load_data : alu_out_q;
  assign bus.retire_count          = retire_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Randomised bench for wb_stage_reg against a slot-level reference model,
// with directed literal checks for reset, loads, dest-zero, stall and flush.
module tb_wb_stage_reg;
  localparam int unsigned WL = 32;
  localparam int unsigned RA = 5;
  localparam int unsigned CW = 32;
`ifdef WB_SUBWORD_LOAD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  wb_stage_reg_if #(.WORD_LENGTH(WL), .REG_ADDR_W(RA), .CNT_W(CW)) bus ();

  wb_stage_reg #(.WORD_LENGTH(WL), .REG_ADDR_W(RA), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: contents of the slot the stage currently presents.
  logic          m_valid, m_we, m_rd, m_known;
  logic [RA-1:0] m_dest;
  logic [WL-1:0] m_data;
  logic [CW-1:0] m_count;

  function automatic logic [WL-1:0] exp_load(input logic [WL-1:0] addr,
                                             input logic [WL-1:0] dm,
                                             input logic [1:0] sz,
                                             input logic sg);
    int unsigned   nbits;
    int unsigned   sh;
    logic [WL-1:0] mask;
    logic [WL-1:0] f;
    nbits = WL;
    sh    = 0;
    if (sz == 2'b10) begin
      nbits = 8;
      sh    = 8 * int'(addr % 4);
    end else if (sz == 2'b01) begin
      nbits = 16;
      sh    = 16 * int'((addr / 2) % 2);
    end
    if (nbits == WL) begin
      f = dm;
    end else begin
      mask = (WL'(1) << nbits) - WL'(1);
      f = (dm >> sh) & mask;
      if (sg && f[nbits-1]) f = f | ~mask;
    end
    return SUBWORD ? f : dm;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_we = 1'b0; m_rd = 1'b0; m_known = 1'b1;
    m_dest = '0; m_data = '0; m_count = '0;
  endtask

  task automatic chk(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("wb_en",  WL'(bus.WB_EN), WL'(m_valid & m_we & (m_dest != '0)));
    chk("rd_out", WL'(bus.MEM_R_ENOut), WL'(m_valid & m_rd));
    chk("count",  WL'(bus.retire_count), WL'(m_count));
    if (m_known) begin
      chk("dest", WL'(bus.WB_Dest), WL'(m_dest));
      chk("data", bus.RegisterFileWriteData, m_data);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic cycle();
    @(posedge clk);
    if (m_valid && !bus.stall) m_count = m_count + CW'(1);
    if (bus.flush) begin
      m_valid = 1'b0; m_we = 1'b0; m_rd = 1'b0; m_known = 1'b0;
    end else if (!bus.stall) begin
      m_valid = bus.valid_in;
      m_we    = bus.MEM_WB_EN;
      m_rd    = bus.MEM_R_EN;
      m_dest  = bus.dest_in;
      m_data  = bus.MEM_R_EN ? exp_load(bus.ALUOut, bus.DataMemoryOut, bus.load_size, bus.load_signed)
                             : bus.ALUOut;
      m_known = 1'b1;
    end
    #1;
    compare();
  endtask

  task automatic drive(input logic v, input logic we, input logic rd, input logic [RA-1:0] d,
                       input logic [WL-1:0] alu, input logic [WL-1:0] dm,
                       input logic [1:0] sz, input logic sg);
    bus.valid_in = v; bus.MEM_WB_EN = we; bus.MEM_R_EN = rd; bus.dest_in = d;
    bus.ALUOut = alu; bus.DataMemoryOut = dm; bus.load_size = sz; bus.load_signed = sg;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst   = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd17, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b10, 1'b1);
    model_reset();

    // Asynchronous reset with busy inputs, before the first clock edge.
    #2;
    chk("rst_wb_en", WL'(bus.WB_EN), '0);
    chk("rst_dest",  WL'(bus.WB_Dest), '0);
    chk("rst_data",  bus.RegisterFileWriteData, '0);
    chk("rst_count", WL'(bus.retire_count), '0);
    chk("rst_rd",    WL'(bus.MEM_R_ENOut), '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_1234, 32'h0, 2'b00, 1'b0);
    cycle();
    chk("alu_wb_en", WL'(bus.WB_EN), WL'(1));
    chk("alu_dest",  WL'(bus.WB_Dest), WL'(7));
    chk("alu_data",  bus.RegisterFileWriteData, 32'h0000_1234);
    chk("alu_cnt0",  WL'(bus.retire_count), WL'(0));
    chk("model_alu", m_data, 32'h0000_1234);

    drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0103, 32'h80FF_0011, 2'b10, 1'b1);
    cycle();
    chk("alu_cnt1",   WL'(bus.retire_count), WL'(1));
    chk("lb_signed",  bus.RegisterFileWriteData, SUBWORD ? 32'hFFFF_FF80 : 32'h80FF_0011);
    chk("model_lb",   m_data, SUBWORD ? 32'hFFFF_FF80 : 32'h80FF_0011);
    chk("lb_rd_out",  WL'(bus.MEM_R_ENOut), WL'(1));

    drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0103, 32'h80FF_0011, 2'b10, 1'b0);
    cycle();
    chk("lbu", bus.RegisterFileWriteData, SUBWORD ? 32'h0000_0080 : 32'h80FF_0011);

    drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0102, 32'h8001_7FFF, 2'b01, 1'b1);
    cycle();
    chk("lh_hi", bus.RegisterFileWriteData, SUBWORD ? 32'hFFFF_8001 : 32'h8001_7FFF);
    chk("model_lh", m_data, SUBWORD ? 32'hFFFF_8001 : 32'h8001_7FFF);

    drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0100, 32'h8001_7FFF, 2'b01, 1'b1);
    cycle();
    chk("lh_lo", bus.RegisterFileWriteData, SUBWORD ? 32'h0000_7FFF : 32'h8001_7FFF);

    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_00AA, 32'h0, 2'b00, 1'b0);
    cycle();
    chk("x0_wb_en", WL'(bus.WB_EN), WL'(0));
    chk("x0_cnt",   WL'(bus.retire_count), WL'(5));

    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_55AA, 32'h0, 2'b00, 1'b0);
    cycle();
    chk("x0_retired", WL'(bus.retire_count), WL'(6));

    // Three stalled cycles with different inputs presented.
    bus.stall = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_FFFF, 32'h1234_5678, 2'b00, 1'b1);
    repeat (3) begin
      cycle();
      chk("stall_data",  bus.RegisterFileWriteData, 32'h0000_55AA);
      chk("stall_dest",  WL'(bus.WB_Dest), WL'(9));
      chk("stall_count", WL'(bus.retire_count), WL'(6));
    end
    bus.stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
    cycle();
    chk("release_count", WL'(bus.retire_count), WL'(7));
    chk("release_wb_en", WL'(bus.WB_EN), WL'(0));

    drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0200, 32'h0BAD_F00D, 2'b00, 1'b0);
    cycle();
    chk("ld_rd_out", WL'(bus.MEM_R_ENOut), WL'(1));
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    cycle();
    chk("flush_wb_en", WL'(bus.WB_EN), WL'(0));
    chk("flush_rd",    WL'(bus.MEM_R_ENOut), WL'(0));
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    for (int i = 0; i < 600; i++) begin
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
            WL'($urandom), WL'($urandom), 2'($urandom), 1'($urandom));
      cycle();
    end

    // Reset arriving mid-stall clears everything without a clock edge.
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd21, 32'h0000_0301, 32'hFFFF_FFFF, 2'b10, 1'b1);
    cycle();
    bus.stall = 1'b1;
    cycle();
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_wb_en", WL'(bus.WB_EN), '0);
    chk("mid_rst_dest",  WL'(bus.WB_Dest), '0);
    chk("mid_rst_data",  bus.RegisterFileWriteData, '0);
    chk("mid_rst_rd",    WL'(bus.MEM_R_ENOut), '0);
    chk("mid_rst_count", WL'(bus.retire_count), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
